f_mem_loader: RTL and testbench



---
 rtl/f_mem_loader.sv | 133 +++++++++++++
 tb/tb_f_mem_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/f_mem_loader.sv
// f_mem_loader: streams filter coefficients into the F-vector memory, zero-pads unused taps,
// waits out the read register and holds filter_valid. Optional macro F_MEM_LOADER_CLEAR_EN adds a post-reset CLEAR.
module f_mem_loader #(
   parameter int WIDTH   = 16,
   parameter int SIZE    = 64,
   parameter int LOGSIZE = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   input  logic [LOGSIZE:0]   cfg_taps,
   input  logic [WIDTH-1:0]   s_data_in,
   input  logic               s_valid_in,
   output logic               s_ready_out,
   output logic [WIDTH-1:0]   f_data_out,
   output logic [LOGSIZE-1:0] f_addr_out,
   output logic               f_wr_en_out,
   output logic               filter_valid,
   input  logic               filter_release,
   output logic               busy
);

   // state    | meaning
   // S_IDLE   | waiting for cfg_valid
   // S_LOAD   | accepting coefficients, one write per handshake
   // S_PAD    | writing zeros from the last tap up to SIZE-1
   // S_SETTLE | one idle cycle for the memory's registered read
   // S_READY  | filter_valid held until filter_release
   // S_CLEAR  | zeroing every address after reset (macro builds only)
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PAD,
      S_SETTLE,
      S_READY
`ifdef F_MEM_LOADER_CLEAR_EN
      , S_CLEAR
`endif
   } state_t;

   localparam logic [LOGSIZE:0] SIZE_W = (LOGSIZE+1)'(SIZE);
   localparam logic [LOGSIZE:0] LAST_W = (LOGSIZE+1)'(SIZE - 1);
   localparam logic [LOGSIZE:0] ONE_W  = (LOGSIZE+1)'(1);

`ifdef F_MEM_LOADER_CLEAR_EN
   localparam state_t RESET_STATE = S_CLEAR;
`else
   localparam state_t RESET_STATE = S_IDLE;
`endif

   state_t             state_q, state_d;
   logic [LOGSIZE:0]   cnt_q, cnt_d;
   logic [LOGSIZE:0]   taps_q, taps_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
         taps_q  <= SIZE_W;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         taps_q  <= taps_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      taps_d       = taps_q;
      s_ready_out  = 1'b0;
      f_wr_en_out  = 1'b0;
      f_addr_out   = '0;
      f_data_out   = '0;
      filter_valid = 1'b0;
      busy         = 1'b1;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (cfg_valid) begin
               // zero and oversize requests both mean a full-length filter
               taps_d  = (cfg_taps == '0 || cfg_taps > SIZE_W) ? SIZE_W : cfg_taps;
               cnt_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            s_ready_out = 1'b1;
            if (s_valid_in) begin
               f_wr_en_out = 1'b1;
               f_addr_out  = cnt_q[LOGSIZE-1:0];
               f_data_out  = s_data_in;
               cnt_d       = cnt_q + ONE_W;
               if (cnt_q == taps_q - ONE_W)
                  state_d = (taps_q < SIZE_W) ? S_PAD : S_SETTLE;
            end
         end
         S_PAD: begin
            f_wr_en_out = 1'b1;
            f_addr_out  = cnt_q[LOGSIZE-1:0];
            cnt_d       = cnt_q + ONE_W;
            if (cnt_q == LAST_W)
               state_d = S_SETTLE;
         end
         S_SETTLE: begin
            state_d = S_READY;
         end
         S_READY: begin
            busy         = 1'b0;
            filter_valid = 1'b1;
            if (filter_release)
               state_d = S_IDLE;
         end
`ifdef F_MEM_LOADER_CLEAR_EN
         S_CLEAR: begin
            f_wr_en_out = 1'b1;
            f_addr_out  = cnt_q[LOGSIZE-1:0];
            cnt_d       = cnt_q + ONE_W;
            if (cnt_q == LAST_W) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_f_mem_loader.sv
// Bench for f_mem_loader: directed and randomized loads checked against a reference of the expected
// write sequence and final memory image. Honours F_MEM_LOADER_CLEAR_EN when the design is built with it.
module tb_f_mem_loader;
   localparam int WIDTH   = 16;
   localparam int SIZE    = 64;
   localparam int LOGSIZE = 6;

   logic               clk = 1'b0;
   logic               reset;
   logic               cfg_valid;
   logic [LOGSIZE:0]   cfg_taps;
   logic [WIDTH-1:0]   s_data_in;
   logic               s_valid_in;
   logic               s_ready_out;
   logic [WIDTH-1:0]   f_data_out;
   logic [LOGSIZE-1:0] f_addr_out;
   logic               f_wr_en_out;
   logic               filter_valid;
   logic               filter_release;
   logic               busy;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] coef   [SIZE];
   logic [WIDTH-1:0] tb_mem [SIZE];

   f_mem_loader #(.WIDTH(WIDTH), .SIZE(SIZE), .LOGSIZE(LOGSIZE)) dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_valid      (cfg_valid),
      .cfg_taps       (cfg_taps),
      .s_data_in      (s_data_in),
      .s_valid_in     (s_valid_in),
      .s_ready_out    (s_ready_out),
      .f_data_out     (f_data_out),
      .f_addr_out     (f_addr_out),
      .f_wr_en_out    (f_wr_en_out),
      .filter_valid   (filter_valid),
      .filter_release (filter_release),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // the F-vector memory the loader writes into
   always @(posedge clk)
      if (f_wr_en_out === 1'b1) tb_mem[f_addr_out] <= f_data_out;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_phase();
      for (int a = 0; a < SIZE; a++) begin
         cfg_valid = 1'($urandom_range(1));
         cfg_taps  = 7'($urandom);
         #1;
         chk("clr_wr", f_wr_en_out, 1);
         chk("clr_addr", f_addr_out, a);
         chk("clr_data", f_data_out, 0);
         chk("clr_busy", busy, 1);
         chk("clr_ready", s_ready_out, 0);
         tick();
      end
      cfg_valid = 1'b0;
   endtask

   task automatic after_reset();
`ifdef F_MEM_LOADER_CLEAR_EN
      clear_phase();
      #1;
`else
      #1;
`endif
      chk("rst_ready", s_ready_out, 0);
      chk("rst_wr", f_wr_en_out, 0);
      chk("rst_addr", f_addr_out, 0);
      chk("rst_data", f_data_out, 0);
      chk("rst_fv", filter_valid, 0);
      chk("rst_busy", busy, 0);
      tick();
   endtask

   task automatic load(input int taps_cfg, input int stall_pct, input bit glitch);
      int eff;
      int stalls;
      eff = (taps_cfg == 0 || taps_cfg > SIZE) ? SIZE : taps_cfg;
      cfg_valid = 1'b1;
      cfg_taps  = 7'(taps_cfg);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_ready", s_ready_out, 0);
      chk("idle_fv", filter_valid, 0);
      chk("idle_wr", f_wr_en_out, 0);
      tick();
      cfg_valid = 1'b0;
      for (int i = 0; i < eff; i++) begin
         stalls = 0;
         do begin
            s_valid_in = ($urandom_range(99) >= stall_pct) || (stalls >= 8);
            s_data_in  = s_valid_in ? coef[i] : 16'($urandom);
            if (glitch) begin
               cfg_valid      = 1'($urandom_range(1));
               cfg_taps       = 7'($urandom);
               filter_release = 1'($urandom_range(1));
            end
            #1;
            chk("load_ready", s_ready_out, 1);
            chk("load_busy", busy, 1);
            chk("load_wr", f_wr_en_out, s_valid_in);
            if (s_valid_in) begin
               chk("load_addr", f_addr_out, i);
               chk("load_data", f_data_out, coef[i]);
            end
            stalls++;
            tick();
         end while (!s_valid_in);
      end
      cfg_valid      = 1'b0;
      filter_release = 1'b0;
      for (int a = eff; a < SIZE; a++) begin
         s_valid_in = 1'($urandom_range(1));
         s_data_in  = 16'($urandom);
         #1;
         chk("pad_ready", s_ready_out, 0);
         chk("pad_wr", f_wr_en_out, 1);
         chk("pad_addr", f_addr_out, a);
         chk("pad_data", f_data_out, 0);
         chk("pad_busy", busy, 1);
         tick();
      end
      s_valid_in = 1'b0;
      #1;
      chk("settle_wr", f_wr_en_out, 0);
      chk("settle_fv", filter_valid, 0);
      chk("settle_busy", busy, 1);
      tick();
      repeat ($urandom_range(1, 4)) begin
         cfg_valid = 1'($urandom_range(1));
         cfg_taps  = 7'($urandom);
         #1;
         chk("ready_fv", filter_valid, 1);
         chk("ready_busy", busy, 0);
         chk("ready_wr", f_wr_en_out, 0);
         chk("ready_sready", s_ready_out, 0);
         tick();
      end
      for (int k = 0; k < SIZE; k++)
         chk($sformatf("mem[%0d]", k), tb_mem[k], (k < eff) ? coef[k] : 16'h0);
      filter_release = 1'b1;
      cfg_valid      = 1'($urandom_range(1));
      #1;
      chk("rel_fv_hold", filter_valid, 1);
      tick();
      filter_release = 1'b0;
      cfg_valid      = 1'b0;
   endtask

   task automatic fill_random();
      for (int k = 0; k < SIZE; k++) coef[k] = 16'($urandom);
   endtask

   initial begin
      reset = 1'b1;
      cfg_valid = 1'b0;
      cfg_taps = '0;
      s_data_in = '0;
      s_valid_in = 1'b0;
      filter_release = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      after_reset();

      for (int k = 0; k < SIZE; k++) coef[k] = 16'(k + 1);
      load(64, 0, 1'b0);

      fill_random();
      for (int k = 0; k < 5; k++) coef[k] = 16'(7 + k);
      load(5, 0, 1'b0);

      fill_random();
      load(2, 50, 1'b0);

      fill_random();
      load(0, 20, 1'b1);

      fill_random();
      load(3, 0, 1'b0);

      fill_random();
      load(100, 10, 1'b1);

      fill_random();
      load(65, 0, 1'b0);

      fill_random();
      load(1, 30, 1'b0);

      for (int r = 0; r < 6; r++) begin
         fill_random();
         load(($urandom_range(1) != 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(1, 63)),
              int'($urandom_range(0, 60)), 1'($urandom_range(1)));
      end

      fill_random();
      cfg_valid = 1'b1;
      cfg_taps  = 7'd20;
      tick();
      cfg_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         s_valid_in = 1'b1;
         s_data_in  = coef[i];
         #1;
         chk("pre_rst_addr", f_addr_out, i);
         tick();
      end
      s_valid_in = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      after_reset();
`ifndef F_MEM_LOADER_CLEAR_EN
      for (int k = 0; k < 10; k++)
         chk("kept_word", tb_mem[k], coef[k]);
`endif

      fill_random();
      load(7, 25, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
